soml_metric_collector: RTL and testbench
========================================

SOML_METRIC_COLLECTOR -- requirements
Module: soml_metric_collector

Interface
REQ-001 The block SHALL have parameter METRIC_W, default 16, giving the width of one unsigned per-address distance metric.
REQ-002 clk  input  1  clock; the block SHALL sample all inputs and update all registers on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  single-cycle pulse that re-arms the block for a new 128-sample sweep.
REQ-005 in_valid  input  1  metric and address inputs are valid this cycle.
REQ-006 in_metric  input  METRIC_W  unsigned distance metric for the current (colS,rowH,Si) address.
REQ-007 addr_colS  input  2  column address tag, range 0..1.
REQ-008 addr_rowH  input  2  row address tag, range 0..3.
REQ-009 addr_Si  input  4  candidate address tag, range 0..15.
REQ-010 out_valid  output  1  single-cycle pulse: best_si and best_metric are final.
REQ-011 best_si  output  4  index of the candidate with the minimum summed metric.
REQ-012 best_metric  output  METRIC_W+3  summed metric of best_si.
REQ-013 done  output  1  level, high while the sweep is complete and further samples are ignored.
REQ-014 seq_err  output  1  sticky flag: an input address tag differed from the expected sweep order.

Function
REQ-015 The sweep order SHALL be colS fastest (0..1), then rowH (0..3), then Si (0..15): 8 samples per Si, 128 samples in total.
REQ-016 The block SHALL keep an internal sample counter (col, row, si) that advances by one on each accepted sample; this counter, not the address tags, SHALL select the candidate being accumulated.
REQ-017 The block SHALL have states ACTIVE and DONE; in ACTIVE a sample is accepted when in_valid=1, and in DONE in_valid SHALL be ignored.
REQ-018 The per-candidate accumulator SHALL be METRIC_W+3 bits wide, which is exact for 8 samples; no saturation or wrap-around SHALL occur.
REQ-019 On the 8th sample of a candidate (col=1,row=3), the block SHALL form sum = acc + in_metric combinationally, SHALL compare it with the running best in the same cycle, and SHALL clear acc.
REQ-020 Replacement SHALL occur only if sum < best_metric (strictly less), so that on ties the lowest Si wins.
REQ-021 best_si and best_metric SHALL update one cycle after the sample that produced the new minimum, and SHALL hold between updates.
REQ-022 On the 128th accepted sample (si=15,row=3,col=1), the state SHALL go to DONE on the next edge; out_valid SHALL be 1 for exactly that one cycle and done SHALL be 1 from then on.
REQ-023 A start pulse in any state SHALL clear acc, the counter, best_metric (to all ones), best_si (to 0), done and out_valid, and SHALL enter ACTIVE; seq_err SHALL be cleared only by rst.
REQ-024 If start and in_valid are both 1 in the same cycle, start SHALL win and the sample SHALL be discarded.
REQ-025 Gaps in in_valid SHALL stall accumulation without changing any state.

Reset
REQ-026 After rst the block SHALL be in ACTIVE with counter 0, acc 0, best_metric all ones, best_si 0, out_valid 0, done 0 and seq_err 0, ready to accept a sweep with no start pulse.
REQ-027 rst asserted mid-sweep SHALL discard all partial sums at the next edge; rst SHALL take priority over start and in_valid.

Configuration
REQ-028 With SOML_SEQ_CHECK_EN defined, each accepted sample whose {addr_Si,addr_rowH,addr_colS} differs from the internal counter SHALL set seq_err on the next edge, and the sample SHALL still be accumulated.
REQ-029 Without SOML_SEQ_CHECK_EN, seq_err SHALL be tied to 0, the address tags SHALL be unused, and all other behaviour SHALL be identical.

Structure
REQ-030 The shared package soml_pkg SHALL hold the constants N_COLS=2, N_ROWS=4, N_SI=16, SAMPLES_PER_SI=8, and the state enumeration.
REQ-031 The address-order comparison SHALL be a sub-module named soml_seq_checker, instantiated only under SOML_SEQ_CHECK_EN.

Verification
REQ-032 The bench SHALL cover: after rst, metric=10 on all 128 samples driven back-to-back -> out_valid pulse 1 cycle after the last sample, best_si=0 (tie rule), best_metric=80, done=1.
REQ-033 The bench SHALL cover: metric=100 everywhere except Si=9, where metric=3 -> best_si=9, best_metric=24.
REQ-034 The bench SHALL cover: the same sweep with in_valid deasserted every other cycle -> identical result, with out_valid 1 cycle after the 128th valid sample.
REQ-035 The bench SHALL cover: start asserted at sample 50, together with in_valid, followed by a full sweep with Si=4 minimal -> the sample at start is dropped, best_si=4, and there is exactly one out_valid.
REQ-036 The bench SHALL cover: with SOML_SEQ_CHECK_EN, addr_Si driven as 3 at sample index 10 -> seq_err=1 next cycle and held through a later start, the result is unaffected, and seq_err clears only on rst; without the macro, seq_err stays 0.
REQ-037 The bench SHALL cover: in_metric all ones (METRIC_W=16) on every sample -> best_metric=0x7FFF8 with no overflow, and samples driven after done are ignored.

Source files
------------

// File: rtl/soml_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// soml_pkg : shared sweep constants and state encoding for the SOML collector
// Revision : 1.0
// ---------------------------------------------------------------------------
package soml_pkg;
  localparam int N_COLS         = 2;
  localparam int N_ROWS         = 4;
  localparam int N_SI           = 16;
  localparam int SAMPLES_PER_SI = 8;
  localparam int N_SAMPLES      = N_SI * SAMPLES_PER_SI;
  localparam int CNT_W          = $clog2(N_SAMPLES);

  typedef enum logic [0:0] {
    ST_ACTIVE = 1'b0,
    ST_DONE   = 1'b1
  } state_t;
endpackage
`default_nettype wire

// File: rtl/soml_seq_checker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// soml_seq_checker : flags an address tag that differs from the sweep counter
// Revision : 1.0
// ---------------------------------------------------------------------------
module soml_seq_checker
  import soml_pkg::*;
(
  input  logic [CNT_W-1:0] cnt,
  input  logic [3:0]       addr_Si,
  input  logic [1:0]       addr_rowH,
  input  logic [1:0]       addr_colS,
  output logic             mismatch
);
  // Counter layout is {si[3:0], row[1:0], col}; colS is a 2-bit tag so bit 1 must be 0.
  assign mismatch = (addr_Si   != cnt[CNT_W-1:3]) ||
                    (addr_rowH != cnt[2:1])       ||
                    (addr_colS != {1'b0, cnt[0]});
endmodule
`default_nettype wire

// File: rtl/soml_metric_collector.sv
`default_nettype none
// ---------------------------------------------------------------------------
// soml_metric_collector : sums 8 metrics per candidate over a 128-sample sweep
//                         and reports the minimum; SOML_SEQ_CHECK_EN adds seq_err.
// Revision : 1.0
// ---------------------------------------------------------------------------
module soml_metric_collector
  import soml_pkg::*;
#(
  parameter int METRIC_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_valid,
  input  logic [METRIC_W-1:0] in_metric,
  input  logic [1:0]          addr_colS,
  input  logic [1:0]          addr_rowH,
  input  logic [3:0]          addr_Si,
  output logic                out_valid,
  output logic [3:0]          best_si,
  output logic [METRIC_W+2:0] best_metric,
  output logic                done,
  output logic                seq_err
);
  localparam int ACC_W = METRIC_W + 3;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   sum;
  logic               accept;
  logic               last_of_si;
  logic               last_sample;

  assign accept      = (state == ST_ACTIVE) && in_valid && !start;
  assign last_of_si  = (cnt[2:0] == 3'(SAMPLES_PER_SI - 1));
  assign last_sample = (cnt == CNT_W'(N_SAMPLES - 1));
  assign sum         = acc + ACC_W'(in_metric);
  assign done        = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_ACTIVE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start)                       state_nxt = ST_ACTIVE;
    else if (accept && last_sample)  state_nxt = ST_DONE;
  end

  always_ff @(posedge clk) begin
    if (rst || start) begin
      cnt         <= '0;
      acc         <= '0;
      best_metric <= '1;
      best_si     <= '0;
      out_valid   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (accept) begin
        cnt <= cnt + CNT_W'(1);
        if (last_of_si) begin
          acc <= '0;
          // Strict compare keeps the lowest Si on ties.
          if (sum < best_metric) begin
            best_metric <= sum;
            best_si     <= cnt[CNT_W-1:3];
          end
        end else begin
          acc <= sum;
        end
        if (last_sample) out_valid <= 1'b1;
      end
    end
  end

`ifdef SOML_SEQ_CHECK_EN
  logic mismatch;

  soml_seq_checker u_seq_checker (
    .cnt       (cnt),
    .addr_Si   (addr_Si),
    .addr_rowH (addr_rowH),
    .addr_colS (addr_colS),
    .mismatch  (mismatch)
  );

  // Sticky across start; only rst clears it.
  always_ff @(posedge clk) begin
    if (rst)                    seq_err <= 1'b0;
    else if (accept && mismatch) seq_err <= 1'b1;
  end
`else
  logic unused_tags;
  assign unused_tags = ^{addr_Si, addr_rowH, addr_colS};
  assign seq_err     = 1'b0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_soml_metric_collector.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_soml_metric_collector : randomized sweeps checked against a sum/argmin model
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_soml_metric_collector;
  localparam int W  = 16;
  localparam int BW = W + 3;
`ifdef SOML_SEQ_CHECK_EN
  localparam logic SEQ = 1'b1;
`else
  localparam logic SEQ = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, start, in_valid;
  logic [W-1:0]  in_metric;
  logic [1:0]    addr_colS, addr_rowH;
  logic [3:0]    addr_Si;
  logic          out_valid, done, seq_err;
  logic [3:0]    best_si;
  logic [BW-1:0] best_metric;

  int n_cmp = 0;
  int n_err = 0;
  int ov_count = 0;
  logic [W-1:0] m [128];

  soml_metric_collector #(.METRIC_W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_metric(in_metric),
    .addr_colS(addr_colS), .addr_rowH(addr_rowH), .addr_Si(addr_Si),
    .out_valid(out_valid), .best_si(best_si), .best_metric(best_metric),
    .done(done), .seq_err(seq_err)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (out_valid === 1'b1) ov_count++;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tags(input int i);
    addr_Si   = i[6:3];
    addr_rowH = i[2:1];
    addr_colS = {1'b0, i[0]};
  endtask

  task automatic pulse_start(input string tag);
    start = 1'b1; in_valid = 1'b0; step(); start = 1'b0;
    chk({tag, "_start_best"}, best_metric, 32'h7FFFF);
    chk({tag, "_start_done"}, done, 0);
  endtask

  task automatic fill_rand(input int lo, input int hi);
    for (int i = 0; i < 128; i++) m[i] = W'($urandom_range(hi, lo));
  endtask

  task automatic set_si(input int s, input logic [W-1:0] v);
    for (int k = 0; k < 8; k++) m[s*8+k] = v;
  endtask

  // Reference: per-candidate sum of its 8 samples, first strict minimum wins.
  function automatic void model(output logic [3:0] bs, output logic [BW-1:0] bm);
    int best;
    best = 32'h7FFFF;
    bs   = 4'd0;
    for (int s = 0; s < 16; s++) begin
      int sum;
      sum = 0;
      for (int k = 0; k < 8; k++) sum += int'(m[s*8+k]);
      if (sum < best) begin best = sum; bs = 4'(s); end
    end
    bm = BW'(best);
  endfunction

  task automatic run_sweep(input string tag, input bit gaps, input int bad_idx);
    logic [3:0]    es;
    logic [BW-1:0] em;
    int ov0;
    model(es, em);
    ov0 = ov_count;
    for (int i = 0; i < 128; i++) begin
      if (gaps && i > 0) begin
        in_valid = 1'b0; in_metric = W'($urandom); step();
      end
      in_valid = 1'b1; in_metric = m[i]; set_tags(i);
      if (i == bad_idx) addr_Si = 4'd3;
      step();
      if (i == bad_idx) chk({tag, "_seq_err"}, seq_err, SEQ);
    end
    in_valid = 1'b0;
    chk({tag, "_out_valid"}, out_valid, 1);
    chk({tag, "_best_si"}, best_si, es);
    chk({tag, "_best_metric"}, best_metric, em);
    chk({tag, "_done"}, done, 1);
    step();
    chk({tag, "_ov_drop"}, out_valid, 0);
    chk({tag, "_done_hold"}, done, 1);
    chk({tag, "_ov_pulses"}, ov_count - ov0, 1);
  endtask

  initial begin
    logic [3:0]    hs;
    logic [BW-1:0] hm;
    int ov0;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_metric = '0;
    addr_Si = '0; addr_rowH = '0; addr_colS = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_best_metric", best_metric, 32'h7FFFF);
    chk("rst_best_si", best_si, 0);
    chk("rst_seq_err", seq_err, 0);

    for (int i = 0; i < 128; i++) m[i] = W'(10);
    run_sweep("tie10", 1'b0, -1);
    chk("tie10_metric80", best_metric, 80);

    pulse_start("si9");
    for (int i = 0; i < 128; i++) m[i] = W'(100);
    set_si(9, W'(3));
    run_sweep("si9", 1'b0, -1);
    chk("si9_metric24", best_metric, 24);

    pulse_start("ties");
    fill_rand(0, 3);
    run_sweep("ties", 1'b0, -1);

    pulse_start("gaps");
    for (int i = 0; i < 128; i++) m[i] = W'(100);
    set_si(9, W'(3));
    run_sweep("gaps", 1'b1, -1);

    pulse_start("restart");
    ov0 = ov_count;
    for (int i = 0; i < 50; i++) begin
      in_valid = 1'b1; in_metric = W'($urandom_range(5, 0)); set_tags(i); step();
    end
    start = 1'b1; in_valid = 1'b1; in_metric = '0; set_tags(50); step();
    start = 1'b0;
    chk("restart_cleared", best_metric, 32'h7FFFF);
    fill_rand(50, 200);
    set_si(4, W'(1));
    run_sweep("restart", 1'b0, -1);
    chk("restart_si4", best_si, 4);
    chk("restart_one_pulse", ov_count - ov0, 1);

    pulse_start("seq");
    fill_rand(0, 1000);
    run_sweep("seq", 1'b0, 10);

    pulse_start("ones");
    chk("ones_seq_err_sticky", seq_err, SEQ);
    for (int i = 0; i < 128; i++) m[i] = '1;
    run_sweep("ones", 1'b0, -1);
    chk("ones_metric", best_metric, 32'h7FFF8);
    model(hs, hm);
    ov0 = ov_count;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_metric = '0; set_tags(i); step();
    end
    in_valid = 1'b0; step();
    chk("after_done_metric", best_metric, hm);
    chk("after_done_si", best_si, hs);
    chk("after_done_done", done, 1);
    chk("after_done_pulses", ov_count - ov0, 0);
    chk("after_done_seq_err", seq_err, SEQ);

    pulse_start("midrst");
    for (int i = 0; i < 30; i++) begin
      in_valid = 1'b1; in_metric = W'($urandom_range(3, 0)); set_tags(i); step();
    end
    rst = 1'b1; start = 1'b1; in_valid = 1'b1; in_metric = '0; step();
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    chk("midrst_seq_err", seq_err, 0);
    chk("midrst_best", best_metric, 32'h7FFFF);
    chk("midrst_done", done, 0);
    fill_rand(0, 20);
    run_sweep("midrst", 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
